// File: rtl/unpacker_pkg.sv
// -----------------------------------------------------------------------------
// unpacker_pkg -- definitions shared by the packer/unpacker accelerator blocks.
//   DEF_IO_DATA_WIDTH : default element width in bits
//   DEF_MEM_BW        : default memory word width in bits
//   unpack_state_e    : word-register state (EMPTY = no word held, DRAIN =
//                       word held and being emitted element by element)
// -----------------------------------------------------------------------------
package unpacker_pkg;

  localparam int DEF_IO_DATA_WIDTH = 8;
  localparam int DEF_MEM_BW        = 128;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } unpack_state_e;

endpackage

// File: rtl/unpacker.sv
// -----------------------------------------------------------------------------
// unpacker -- splits a packed memory word into NUM_ELEMS elements, emitted in
// index order 0..NUM_ELEMS-1. Element 0 is the most significant slice.
//
// Ports
//   clk        : clock, all state on rising edge
//   arst_n_in  : asynchronous active-low reset
//   word_in    : packed memory word       (MEM_BW bits)
//   word_valid : word_in valid
//   word_ready : a word is accepted this cycle (registered)
//   elem_out   : current element          (IO_DATA_WIDTH bits, registered)
//   elem_idx   : index of elem_out within its word
//   elem_valid : elem_out valid (registered, independent of elem_ready)
//   elem_ready : consumer accepts elem_out
//   elem_last  : elem_out is the final element of its word
//
// Build option
//   UNPACKER_PREFETCH_EN : adds a prefetch word register so the next word can
//                          be accepted during DRAIN and follow the last element
//                          with no bubble. Without it word_ready is only high
//                          in EMPTY, leaving one bubble cycle between words.
// -----------------------------------------------------------------------------
module unpacker
  import unpacker_pkg::*;
#(
  parameter  int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
  parameter  int MEM_BW        = DEF_MEM_BW,
  localparam int NUM_ELEMS     = MEM_BW / IO_DATA_WIDTH,
  localparam int IDX_W         = $clog2(NUM_ELEMS)
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [MEM_BW-1:0]        word_in,
  input  logic                     word_valid,
  output logic                     word_ready,
  output logic [IO_DATA_WIDTH-1:0] elem_out,
  output logic [IDX_W-1:0]         elem_idx,
  output logic                     elem_valid,
  input  logic                     elem_ready,
  output logic                     elem_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  // Element idx of a word: element 0 sits at the top of the word.
  function automatic logic [IO_DATA_WIDTH-1:0] slice_elem(
    input logic [MEM_BW-1:0] word,
    input logic [IDX_W-1:0]  idx
  );
    int shamt;
    shamt = IO_DATA_WIDTH * (NUM_ELEMS - 1 - int'(idx));
    return IO_DATA_WIDTH'(word >> shamt);
  endfunction

  unpack_state_e            state_q, state_d;
  logic [MEM_BW-1:0]        active_q, active_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IO_DATA_WIDTH-1:0] elem_out_q, elem_out_d;
  logic                     elem_valid_q, elem_valid_d;
  logic                     elem_last_q, elem_last_d;
  logic                     word_ready_q, word_ready_d;
`ifdef UNPACKER_PREFETCH_EN
  logic [MEM_BW-1:0]        pf_q, pf_d;
  logic                     pf_valid_q, pf_valid_d;
`endif

  logic word_xfer_s, elem_xfer_s, last_xfer_s;

  assign word_xfer_s = word_valid && word_ready_q;
  assign elem_xfer_s = elem_valid_q && elem_ready;
  assign last_xfer_s = elem_xfer_s && (idx_q == LAST_IDX);

  // Next-state and next-output computation for the word registers.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    idx_d    = idx_q;
`ifdef UNPACKER_PREFETCH_EN
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (word_xfer_s) begin
          active_d = word_in;
          idx_d    = {IDX_W{1'b0}};
          state_d  = ST_DRAIN;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_DRAIN: begin
`ifdef UNPACKER_PREFETCH_EN
        if (last_xfer_s) begin
          idx_d = {IDX_W{1'b0}};
          if (pf_valid_q) begin
            // Prefetched word becomes active; a same-cycle word refills prefetch.
            active_d   = pf_q;
            pf_d       = word_xfer_s ? word_in : pf_q;
            pf_valid_d = word_xfer_s;
          end else if (word_xfer_s) begin
            active_d = word_in;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          if (elem_xfer_s) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = idx_q;
          end
          if (word_xfer_s) begin
            pf_d       = word_in;
            pf_valid_d = 1'b1;
          end else begin
            pf_valid_d = pf_valid_q;
          end
        end
`else
        if (last_xfer_s) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_EMPTY;
        end else if (elem_xfer_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
`endif
      end
      default: begin
        state_d = ST_EMPTY;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase

    elem_valid_d = (state_d == ST_DRAIN);
    if (elem_valid_d) begin
      elem_out_d = slice_elem(active_d, idx_d);
    end else begin
      elem_out_d = {IO_DATA_WIDTH{1'b0}};
    end
    elem_last_d = elem_valid_d && (idx_d == LAST_IDX);
`ifdef UNPACKER_PREFETCH_EN
    word_ready_d = !pf_valid_d;
`else
    word_ready_d = (state_d == ST_EMPTY);
`endif
  end

  // State and registered outputs; reset discards active and prefetched words.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q      <= ST_EMPTY;
      active_q     <= {MEM_BW{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      elem_out_q   <= {IO_DATA_WIDTH{1'b0}};
      elem_valid_q <= 1'b0;
      elem_last_q  <= 1'b0;
      word_ready_q <= 1'b0;
`ifdef UNPACKER_PREFETCH_EN
      pf_q         <= {MEM_BW{1'b0}};
      pf_valid_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      idx_q        <= idx_d;
      elem_out_q   <= elem_out_d;
      elem_valid_q <= elem_valid_d;
      elem_last_q  <= elem_last_d;
      word_ready_q <= word_ready_d;
`ifdef UNPACKER_PREFETCH_EN
      pf_q         <= pf_d;
      pf_valid_q   <= pf_valid_d;
`endif
    end
  end

  assign word_ready = word_ready_q;
  assign elem_out   = elem_out_q;
  assign elem_idx   = idx_q;
  assign elem_valid = elem_valid_q;
  assign elem_last  = elem_last_q;

endmodule

// File: tb/tb_unpacker.sv
// -----------------------------------------------------------------------------
// tb_unpacker -- scoreboard bench for unpacker. Inputs are driven on the
// falling edge; the outputs seen at that moment are the ones the next rising
// edge transfers, so word/element transfers are decided there. Expected
// elements are queued at word acceptance and popped at element transfer.
// -----------------------------------------------------------------------------
module tb_unpacker;

  localparam int W  = 8;
  localparam int BW = 128;
  localparam int N  = 16;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic [BW-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic [W-1:0]  elem_out;
  logic [3:0]    elem_idx;
  logic          elem_valid;
  logic          elem_ready;
  logic          elem_last;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  unpacker #(.IO_DATA_WIDTH(W), .MEM_BW(BW)) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .elem_out(elem_out), .elem_idx(elem_idx), .elem_valid(elem_valid),
    .elem_ready(elem_ready), .elem_last(elem_last)
  );

  // Queue the 16 expected elements of a word (element 0 = top byte).
  task automatic push_word(input logic [BW-1:0] w);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.data = w[BW-1-W*k -: W];
      e.idx  = 4'(k);
      e.last = (k == N-1);
      sb.push_back(e);
    end
  endtask

  // One cycle: drive inputs on the falling edge and report which transfers
  // the following rising edge will perform.
  task automatic drive(input logic wv, input logic [BW-1:0] w, input logic er,
                       output bit wx, output bit ex);
    @(negedge clk);
    word_valid = wv;
    word_in    = w;
    elem_ready = er;
    wx = wv && word_ready;
    ex = elem_valid && er;
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0; word_valid = 1'b0; word_in = '0; elem_ready = 1'b0;
    #1;
    checks++;
    if (elem_valid !== 1'b0 || elem_last !== 1'b0 || elem_idx !== 4'd0 ||
        elem_out !== 8'h00 || word_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got valid=%b last=%b idx=%0d out=%h wr=%b expected all 0",
               elem_valid, elem_last, elem_idx, elem_out, word_ready);
    end
    repeat (3) @(negedge clk);
    arst_n_in = 1'b1;
    #1;
    checks++;
    if (word_ready !== 1'b0) begin
      failures++; $display("FAIL reset_release_wr got=%b expected 0", word_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (word_ready !== 1'b1) begin
      failures++; $display("FAIL reset_first_edge_wr got=%b expected 1", word_ready);
    end
  endtask

  task automatic test_basic();
    bit wx, ex; exp_t e; int popped = 0; logic [BW-1:0] w;
    for (int k = 0; k < N; k++) w[BW-1-W*k -: W] = 8'(k);
    drive(1'b1, w, 1'b1, wx, ex);
    checks++;
    if (!wx) begin failures++; $display("FAIL basic_accept got=%0b expected 1", wx); end
    if (wx) push_word(w);
    drive(1'b0, '0, 1'b1, wx, ex);
    checks++;
    if (elem_valid !== 1'b1 || elem_idx !== 4'd0) begin
      failures++;
      $display("FAIL basic_latency got valid=%b idx=%0d expected valid=1 idx=0", elem_valid, elem_idx);
    end
    for (int cyc = 0; cyc < 40 && popped < N; cyc++) begin
      if (cyc > 0) drive(1'b0, '0, 1'b1, wx, ex);
      if (ex) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL basic_extra got out=%h idx=%0d expected none", elem_out, elem_idx);
        end else begin
          e = sb.pop_front(); popped++;
          if (elem_out !== e.data || elem_idx !== e.idx || elem_last !== e.last) begin
            failures++;
            $display("FAIL basic_elem got out=%h idx=%0d last=%b expected out=%h idx=%0d last=%b",
                     elem_out, elem_idx, elem_last, e.data, e.idx, e.last);
          end
        end
      end
    end
    checks++;
    if (popped != N) begin failures++; $display("FAIL basic_count got=%0d expected %0d", popped, N); end
    drive(1'b0, '0, 1'b1, wx, ex);
    checks++;
    if (elem_valid !== 1'b0) begin failures++; $display("FAIL basic_idle got valid=%b expected 0", elem_valid); end
  endtask

  task automatic test_backpressure();
    bit wx, ex, stall; exp_t e; int popped = 0; logic [BW-1:0] w;
    logic [W-1:0] p_out; logic [3:0] p_idx;
    for (int k = 0; k < N; k++) w[BW-1-W*k -: W] = 8'(8'h40 + k);
    drive(1'b1, w, 1'b0, wx, ex);
    if (wx) push_word(w);
    stall = 1'b0;
    for (int cyc = 0; cyc < 80 && popped < N; cyc++) begin
      drive(1'b0, '0, logic'(cyc % 2), wx, ex);
      if (stall) begin
        checks++;
        if (elem_valid !== 1'b1 || elem_out !== p_out || elem_idx !== p_idx) begin
          failures++;
          $display("FAIL bp_stable got valid=%b out=%h idx=%0d expected valid=1 out=%h idx=%0d",
                   elem_valid, elem_out, elem_idx, p_out, p_idx);
        end
      end
      stall = elem_valid && !elem_ready;
      p_out = elem_out; p_idx = elem_idx;
      if (ex) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL bp_extra got out=%h idx=%0d expected none", elem_out, elem_idx);
        end else begin
          e = sb.pop_front(); popped++;
          if (elem_out !== e.data || elem_idx !== e.idx || elem_last !== e.last) begin
            failures++;
            $display("FAIL bp_elem got out=%h idx=%0d last=%b expected out=%h idx=%0d last=%b",
                     elem_out, elem_idx, elem_last, e.data, e.idx, e.last);
          end
        end
      end
    end
    checks++;
    if (popped != N) begin failures++; $display("FAIL bp_count got=%0d expected %0d", popped, N); end
  endtask

  task automatic test_back_to_back();
    bit wx, ex, started = 1'b0; exp_t e; int popped = 0, sent = 0, gaps = 0, exp_gaps;
    logic [BW-1:0] wa, wb;
`ifdef UNPACKER_PREFETCH_EN
    exp_gaps = 0;
`else
    exp_gaps = 1;
`endif
    for (int k = 0; k < N; k++) begin
      wa[BW-1-W*k -: W] = 8'(8'h10 + k);
      wb[BW-1-W*k -: W] = 8'(8'h20 + k);
    end
    for (int cyc = 0; cyc < 100 && popped < 2*N; cyc++) begin
      drive(logic'(sent < 2), (sent == 0) ? wa : wb, 1'b1, wx, ex);
      if (wx) begin push_word(word_in); sent++; end
      if (elem_valid) started = 1'b1;
      else if (started) gaps++;
      if (ex) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_extra got out=%h idx=%0d expected none", elem_out, elem_idx);
        end else begin
          e = sb.pop_front(); popped++;
          if (elem_out !== e.data || elem_idx !== e.idx || elem_last !== e.last) begin
            failures++;
            $display("FAIL b2b_elem got out=%h idx=%0d last=%b expected out=%h idx=%0d last=%b",
                     elem_out, elem_idx, elem_last, e.data, e.idx, e.last);
          end
        end
      end
    end
    checks++;
    if (popped != 2*N) begin failures++; $display("FAIL b2b_count got=%0d expected %0d", popped, 2*N); end
    checks++;
    if (gaps != exp_gaps) begin failures++; $display("FAIL b2b_gaps got=%0d expected %0d", gaps, exp_gaps); end
  endtask

  task automatic test_hold_ignore();
    bit wx, ex; exp_t e; int popped = 0, sent = 0, stalls = 0;
    for (int cyc = 0; cyc < 200 && popped < 3*N; cyc++) begin
      drive(logic'(sent < 3), {$urandom, $urandom, $urandom, $urandom}, 1'b1, wx, ex);
      if (word_valid && !word_ready) stalls++;
      if (wx) begin push_word(word_in); sent++; end
      if (ex) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL hold_extra got out=%h idx=%0d expected none", elem_out, elem_idx);
        end else begin
          e = sb.pop_front(); popped++;
          if (elem_out !== e.data || elem_idx !== e.idx || elem_last !== e.last) begin
            failures++;
            $display("FAIL hold_elem got out=%h idx=%0d last=%b expected out=%h idx=%0d last=%b",
                     elem_out, elem_idx, elem_last, e.data, e.idx, e.last);
          end
        end
      end
    end
    checks++;
    if (popped != 3*N) begin failures++; $display("FAIL hold_count got=%0d expected %0d", popped, 3*N); end
    checks++;
    if (stalls == 0) begin failures++; $display("FAIL hold_stall got=%0d stall cycles expected >0", stalls); end
  endtask

  task automatic test_reset_mid();
    bit wx, ex, hit = 1'b0, sent_c = 1'b0; exp_t e; int popped = 0, sent = 0, late = 0;
    logic [BW-1:0] wa, wb, wc;
    for (int k = 0; k < N; k++) begin
      wa[BW-1-W*k -: W] = 8'(8'h60 + k);
      wb[BW-1-W*k -: W] = 8'(8'h70 + k);
      wc[BW-1-W*k -: W] = 8'(8'h50 + k);
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (elem_valid && elem_idx == 4'd7) begin hit = 1'b1; break; end
      word_valid = (sent < 2); word_in = (sent == 0) ? wa : wb; elem_ready = 1'b1;
      if (word_valid && word_ready) begin push_word(word_in); sent++; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rst_mid_reach got=0 expected idx 7 reached"); end
    arst_n_in = 1'b0; word_valid = 1'b0; elem_ready = 1'b0;
    #1;
    checks++;
    if (elem_valid !== 1'b0 || elem_idx !== 4'd0 || word_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_clear got valid=%b idx=%0d wr=%b expected 0 0 0", elem_valid, elem_idx, word_ready);
    end
    sb.delete();
    @(negedge clk);
    arst_n_in = 1'b1;
    for (int cyc = 0; cyc < 60 && popped < N; cyc++) begin
      drive(!sent_c, wc, 1'b1, wx, ex);
      if (wx) begin push_word(wc); sent_c = 1'b1; end
      if (ex) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rst_mid_extra got out=%h idx=%0d expected none", elem_out, elem_idx);
        end else begin
          e = sb.pop_front(); popped++;
          if (elem_out !== e.data || elem_idx !== e.idx || elem_last !== e.last) begin
            failures++;
            $display("FAIL rst_mid_elem got out=%h idx=%0d last=%b expected out=%h idx=%0d last=%b",
                     elem_out, elem_idx, elem_last, e.data, e.idx, e.last);
          end
        end
      end
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(1'b0, '0, 1'b1, wx, ex);
      if (elem_valid) late++;
    end
    checks++;
    if (popped != N || late != 0) begin
      failures++; $display("FAIL rst_mid_after got popped=%0d stale=%0d expected %0d 0", popped, late, N);
    end
  endtask

  task automatic test_round_trip();
    bit wx, ex, have = 1'b0; exp_t e, q; int popped = 0, sent = 0;
    logic [W-1:0] elems [N]; logic [BW-1:0] w;
    for (int cyc = 0; cyc < 20000 && popped < 100*N; cyc++) begin
      if (!have && sent < 100) begin
        for (int k = 0; k < N; k++) begin
          elems[k] = 8'($urandom);
          w[BW-1-W*k -: W] = elems[k];
        end
        have = 1'b1;
      end
      drive(have && ($urandom_range(0, 3) != 0), w, ($urandom_range(0, 3) != 0), wx, ex);
      if (wx) begin
        for (int k = 0; k < N; k++) begin
          q.data = elems[k]; q.idx = 4'(k); q.last = (k == N-1); sb.push_back(q);
        end
        sent++; have = 1'b0;
      end
      if (ex) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rt_extra got out=%h idx=%0d expected none", elem_out, elem_idx);
        end else begin
          e = sb.pop_front(); popped++;
          if (elem_out !== e.data || elem_idx !== e.idx || elem_last !== e.last) begin
            failures++;
            $display("FAIL rt_elem got out=%h idx=%0d last=%b expected out=%h idx=%0d last=%b",
                     elem_out, elem_idx, elem_last, e.data, e.idx, e.last);
          end
        end
      end
    end
    checks++;
    if (popped != 100*N || sb.size() != 0) begin
      failures++; $display("FAIL rt_count got=%0d left=%0d expected %0d 0", popped, sb.size(), 100*N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_hold_ignore();
    test_reset_mid();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 8: width of one element.
REQ-002 SHALL have parameter MEM_BW, default 128: memory word width; a legal configuration has MEM_BW an integer multiple of IO_DATA_WIDTH.
REQ-003 SHALL derive localparam NUM_ELEMS = MEM_BW/IO_DATA_WIDTH (16 at defaults) and IDX_W = $clog2(NUM_ELEMS).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 arst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 word_in  input  MEM_BW  packed memory word; element 0 occupies bits [MEM_BW-1 : MEM_BW-IO_DATA_WIDTH], element k occupies the slice IO_DATA_WIDTH*k lower.
REQ-007 word_valid  input  1  word_in is valid.
REQ-008 word_ready  output  1  unpacker accepts a word this cycle.
REQ-009 elem_out  output  IO_DATA_WIDTH  current element.
REQ-010 elem_idx  output  IDX_W  index (0..NUM_ELEMS-1) of elem_out within its word.
REQ-011 elem_valid  output  1  elem_out is valid.
REQ-012 elem_ready  input  1  consumer accepts elem_out.
REQ-013 elem_last  output  1  high with elem_valid when elem_idx == NUM_ELEMS-1.

Function
REQ-014 A word transfer SHALL occur on a rising edge with word_valid && word_ready; an element transfer on elem_valid && elem_ready.
REQ-015 Elements SHALL be emitted in index order 0..NUM_ELEMS-1, exactly inverting the packer bit mapping.
REQ-016 Active register state machine: EMPTY (no word held) and DRAIN (word held, elem_idx counting).
REQ-017 EMPTY -> DRAIN on word transfer; elem_valid SHALL rise the cycle after acceptance (latency 1) with elem_idx = 0.
REQ-018 In DRAIN, each element transfer SHALL increment elem_idx; idx, elem_out, elem_valid SHALL hold stable while elem_ready is low.
REQ-019 On the transfer with elem_last, the state machine SHALL load the next word if one is available (REQ-025/027), else return to EMPTY with elem_valid low next cycle.
REQ-020 elem_idx SHALL wrap to 0 after NUM_ELEMS-1; no partial words.
REQ-021 elem_out SHALL be a registered slice of the held word selected by elem_idx (no combinational path from word_in to elem_out).
REQ-022 word_valid high with word_ready low SHALL not alter state; word_in SHALL be sampled only on transfer.
REQ-023 elem_valid SHALL never depend combinationally on elem_ready.

Reset
REQ-024 While arst_n_in is low: state EMPTY, elem_valid 0, elem_last 0, elem_idx 0, elem_out 0, word_ready 0; after release word_ready SHALL be 1 from the first clock edge; assertion mid-word SHALL discard held and prefetched data.

Configuration
REQ-025 Macro UNPACKER_PREFETCH_EN: when defined, a second word register SHALL exist; word_ready = prefetch register empty (registered), so a word can be accepted during DRAIN and the first element of the next word follows elem_last transfer with zero bubble cycles.
REQ-026 With the macro, elem_last transfer and word transfer in the same cycle SHALL move prefetch to active and capture the new word into prefetch.
REQ-027 When undefined: no prefetch register; word_ready = (state == EMPTY), giving exactly one bubble cycle between words; all other behaviour identical.

Structure
REQ-028 IO_DATA_WIDTH/MEM_BW defaults and the state enum type SHALL be defined in the shared accelerator package, also used by packer.
REQ-029 Single module; no sub-module; the word register pair SHALL be written directly in this block.

Verification
REQ-030 Reset then word 0x000102...0F with elem_ready=1 -> elem_out 0x00..0x0F, idx 0..15, elem_last only on 0x0F, first elem_valid one cycle after acceptance.
REQ-031 Backpressure: elem_ready toggled 1/0 per cycle -> 16 elements in order, outputs stable in stall cycles, no loss or duplicate.
REQ-032 Back-to-back words A=0x10..0x1F, B=0x20..0x2F, word_valid held high -> with PREFETCH_EN 32 consecutive elem_valid cycles; without, exactly one gap cycle after 0x1F.
REQ-033 arst_n_in pulsed low at idx 7 -> elem_valid 0 immediately; next word restarts at idx 0 with its own data.
REQ-034 word_valid held high while word_ready low -> word_in changes before acceptance ignored; only value at transfer edge emitted.
REQ-035 Round trip: packer output fed to unpacker for 100 random words -> unpacked elements equal packer inputs bit-exact.
